// File: rtl/inst_fifo_multiport_pkg.sv
// Shared processor types for the multi-port instruction FIFO.
// Slot payload, global/local control bundles and lane limits.
package inst_fifo_multiport_pkg;

  localparam int MAX_LANES = 4;
  localparam int SLOT_W    = 64;

  typedef struct packed {
    logic clk;
    logic rst;
  } global_t;

  typedef struct packed {
    logic flush;
  } local_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } inst_fifo_slot_t;

endpackage

// File: rtl/inst_fifo_multiport_popcount.sv
// Valid-mask to lane count.
// Pure combinational; used for write-pointer advance.
module lane_popcount #(
  parameter int N  = 2,
  parameter int CW = $clog2(N) + 1
) (
  input  logic [N-1:0]  mask_i,
  output logic [CW-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < N; i++) begin
      count_o = count_o + CW'(mask_i[i]);
    end
  end

endmodule

// File: rtl/inst_fifo_multiport.sv
// Multi-lane in/out instruction FIFO with variable pointer steps.
// Slot array is reset-free; only the occupancy accounting is cleared.
module inst_fifo_multiport
  import inst_fifo_multiport_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int WR_PORTS = 2,
  parameter int RD_PORTS = 2,
  parameter int AFULL_TH = DEPTH - WR_PORTS,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = PW + 1,
  localparam int RNW     = $clog2(RD_PORTS) + 1
) (
  input  global_t                         system_i,
  input  local_t                          cntl_i,
  input  logic [WR_PORTS-1:0]             wr_valid_i,
  input  inst_fifo_slot_t [WR_PORTS-1:0]  wr_data_i,
  output logic                            wr_ready_o,
  input  logic [RNW-1:0]                  rd_num_i,
  output inst_fifo_slot_t [RD_PORTS-1:0]  rd_data_o,
  output logic [RD_PORTS-1:0]             rd_valid_o,
  output logic [CW-1:0]                   count_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic                            almost_full_o,
  output logic                            rd_err_o,
  output logic [PW-1:0]                   head_ptr_o
);

  localparam int PCW = $clog2(WR_PORTS) + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] WRP_C   = CW'(WR_PORTS);
  localparam logic [CW-1:0] RDP_C   = CW'(RD_PORTS);
  localparam logic [CW-1:0] AF_C    = CW'(AFULL_TH);

  logic clk;
  logic rst;
  logic flush;

  assign clk   = system_i.clk;
  assign rst   = system_i.rst;
  assign flush = cntl_i.flush;

  inst_fifo_slot_t slots_q [DEPTH];

  logic [PW-1:0]  wp_q, wp_d;
  logic [PW-1:0]  rp_q, rp_d;
  logic [CW-1:0]  count_q, count_d;
  logic           rd_err_q, rd_err_d;

  logic [PCW-1:0] wr_pop;
  logic [CW-1:0]  free;
  logic           wr_acc;
  logic [CW-1:0]  n_wr;
  logic [CW-1:0]  rd_req;
  logic [CW-1:0]  grant;
  logic           over;

  lane_popcount #(
    .N  (WR_PORTS),
    .CW (PCW)
  ) u_wr_pop (
    .mask_i  (wr_valid_i),
    .count_o (wr_pop)
  );

  // No credit for same-cycle reads: readiness uses start-of-cycle count.
  always_comb begin
    free       = DEPTH_C - count_q;
    wr_ready_o = (free >= WRP_C);
    wr_acc     = wr_ready_o && !flush;
    n_wr       = wr_acc ? CW'(wr_pop) : '0;
    rd_req     = CW'(rd_num_i);
    grant      = rd_req;
    if (grant > count_q) grant = count_q;
    if (grant > RDP_C)   grant = RDP_C;
    over       = (rd_req > count_q) || (rd_req > RDP_C);
  end

  always_comb begin
    wp_d     = wp_q;
    rp_d     = rp_q;
    count_d  = count_q;
    rd_err_d = 1'b0;
    if (flush) begin
      wp_d     = '0;
      rp_d     = '0;
      count_d  = '0;
      rd_err_d = 1'b0;
    end else begin
      wp_d     = wp_q + PW'(n_wr);
      rp_d     = rp_q + PW'(grant);
      count_d  = count_q + n_wr - grant;
      rd_err_d = over;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q     <= '0;
      rp_q     <= '0;
      count_q  <= '0;
      rd_err_q <= 1'b0;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      count_q  <= count_d;
      rd_err_q <= rd_err_d;
    end
  end

  // Power-of-two depth: pointer arithmetic wraps for free.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WR_PORTS; i++) begin
      if (!rst && wr_acc && wr_valid_i[i]) begin
        slots_q[wp_q + PW'(i)] <= wr_data_i[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < RD_PORTS; i++) begin
      rd_data_o[i]  = slots_q[rp_q + PW'(i)];
      rd_valid_o[i] = (CW'(i) < count_q);
    end
  end

  assign count_o       = count_q;
  assign full_o        = (count_q == DEPTH_C);
  assign empty_o       = (count_q == '0);
  assign almost_full_o = (count_q >= AF_C);
  assign rd_err_o      = rd_err_q;
  assign head_ptr_o    = rp_q;

endmodule

// File: tb/tb_inst_fifo_multiport.sv
// Directed bench for inst_fifo_multiport (DEPTH=16, 2 write, 2 read lanes).
// Queue scoreboard plus hand-computed checkpoints.
module tb_inst_fifo_multiport;
  import inst_fifo_multiport_pkg::*;

  logic clk;
  logic rst;
  global_t sys;
  local_t cntl;
  logic [1:0] wv;
  inst_fifo_slot_t [1:0] wd;
  logic wr_ready;
  logic [1:0] rn;
  inst_fifo_slot_t [1:0] rd;
  logic [1:0] rv;
  logic [4:0] cnt;
  logic full;
  logic empty;
  logic af;
  logic err;
  logic [3:0] head;

  assign sys = {clk, rst};

  inst_fifo_multiport dut (
    .system_i      (sys),
    .cntl_i        (cntl),
    .wr_valid_i    (wv),
    .wr_data_i     (wd),
    .wr_ready_o    (wr_ready),
    .rd_num_i      (rn),
    .rd_data_o     (rd),
    .rd_valid_o    (rv),
    .count_o       (cnt),
    .full_o        (full),
    .empty_o       (empty),
    .almost_full_o (af),
    .rd_err_o      (err),
    .head_ptr_o    (head)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  inst_fifo_slot_t mq[$];
  int mhead = 0;
  int seq = 0;
  bit exp_err = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic inst_fifo_slot_t mk(input int n);
    inst_fifo_slot_t s;
    s.pc   = 32'h1000 + 32'(n) * 32'd4;
    s.inst = 32'hA000_0000 | 32'(n);
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic verify();
    int sz;
    sz = mq.size();
    check("count", 64'(cnt), 64'(sz));
    check("head", 64'(head), 64'(mhead));
    check("empty", 64'(empty), 64'(sz == 0));
    check("full", 64'(full), 64'(sz == 16));
    check("afull", 64'(af), 64'(sz >= 14));
    check("rd_err", 64'(err), 64'(exp_err));
    for (int i = 0; i < 2; i++) begin
      check("rd_valid", 64'(rv[i]), 64'(i < sz));
      if (i < sz) check("rd_data", rd[i], mq[i]);
    end
  endtask

  task automatic cyc(input logic [1:0] v, input logic [1:0] n,
                     input logic fl);
    int sz;
    int g;
    int ni;
    bit rdy;
    sz  = mq.size();
    ni  = int'(n);
    rdy = (16 - sz) >= 2;
    g   = ni;
    if (g > sz) g = sz;
    if (g > 2) g = 2;
    check("wr_ready", 64'(wr_ready), 64'(rdy));
    wv = v;
    wd[0] = mk(seq);
    wd[1] = mk(seq + 1);
    rn = n;
    cntl.flush = fl;
    step();
    wv = '0;
    rn = '0;
    cntl.flush = 1'b0;
    if (fl) begin
      mq.delete();
      mhead = 0;
      exp_err = 0;
    end else begin
      for (int k = 0; k < g; k++) void'(mq.pop_front());
      mhead = (mhead + g) % 16;
      if (rdy) begin
        for (int k = 0; k < 2; k++)
          if (v[k]) mq.push_back(mk(seq + k));
      end
      exp_err = (ni > sz) || (ni > 2);
    end
    seq += 2;
    verify();
  endtask

  task automatic do_reset(input logic [1:0] v, input logic fl);
    rst = 1'b1;
    wv = v;
    rn = 2'd1;
    cntl.flush = fl;
    step();
    rst = 1'b0;
    wv = '0;
    rn = '0;
    cntl.flush = 1'b0;
    mq.delete();
    mhead = 0;
    exp_err = 0;
    verify();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    wv = '0;
    wd = '0;
    rn = '0;
    cntl.flush = 1'b0;
    step();
    do_reset(2'b00, 1'b0);
    check("rst_wr_ready", 64'(wr_ready), 64'd1);
    check("rst_count", 64'(cnt), 64'd0);

    // Two-lane write becomes visible next cycle
    seq = 0;
    cyc(2'b11, 2'd0, 1'b0);
    check("w2_count", 64'(cnt), 64'd2);
    check("w2_rv", 64'(rv), 64'd3);
    check("w2_d0", rd[0], mk(0));
    check("w2_d1", rd[1], mk(1));

    // Fill to threshold, refuse write at 15
    cyc(2'b00, 2'd0, 1'b1);
    for (int i = 0; i < 7; i++) cyc(2'b11, 2'd0, 1'b0);
    check("f14_count", 64'(cnt), 64'd14);
    check("f14_ready", 64'(wr_ready), 64'd1);
    cyc(2'b01, 2'd0, 1'b0);
    check("f15_ready", 64'(wr_ready), 64'd0);
    check("f15_af", 64'(af), 64'd1);
    cyc(2'b11, 2'd0, 1'b0);
    check("f15_drop", 64'(cnt), 64'd15);
    cyc(2'b00, 2'd3, 1'b0);
    check("over_rd_err", 64'(err), 64'd1);
    check("over_count", 64'(cnt), 64'd13);
    for (int i = 0; i < 7; i++) cyc(2'b00, 2'd2, 1'b0);
    check("drain_empty", 64'(empty), 64'd1);

    // Pointer wrap: park both pointers at 15
    do_reset(2'b00, 1'b0);
    cyc(2'b01, 2'd0, 1'b0);
    for (int i = 0; i < 14; i++) cyc(2'b01, 2'd1, 1'b0);
    cyc(2'b00, 2'd1, 1'b0);
    check("wrap_head15", 64'(head), 64'd15);
    cyc(2'b11, 2'd0, 1'b0);
    check("wrap_rv", 64'(rv), 64'd3);
    cyc(2'b00, 2'd2, 1'b0);
    check("wrap_head1", 64'(head), 64'd1);

    // Over-read at count 1
    cyc(2'b01, 2'd0, 1'b0);
    cyc(2'b00, 2'd2, 1'b0);
    check("c1_err", 64'(err), 64'd1);
    check("c1_empty", 64'(empty), 64'd1);
    cyc(2'b00, 2'd0, 1'b0);
    check("c1_err_pulse", 64'(err), 64'd0);

    // Flush overrides same-cycle write and read
    for (int i = 0; i < 4; i++) cyc(2'b11, 2'd0, 1'b0);
    check("fl_pre", 64'(cnt), 64'd8);
    cyc(2'b11, 2'd3, 1'b1);
    check("fl_count", 64'(cnt), 64'd0);
    check("fl_rv", 64'(rv), 64'd0);
    check("fl_err", 64'(err), 64'd0);

    // Steady state at count 5
    cyc(2'b11, 2'd0, 1'b0);
    cyc(2'b11, 2'd0, 1'b0);
    cyc(2'b01, 2'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(2'b11, 2'd2, 1'b0);
      check("ss_count", 64'(cnt), 64'd5);
    end

    // Reset mid-operation beats flush, write and read
    do_reset(2'b11, 1'b1);
    check("mid_rst_count", 64'(cnt), 64'd0);
    check("mid_rst_head", 64'(head), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
